// File: rtl/ie_stack_seq_pkg.sv
// ---------------------------------------------------------------------------
// ie_stack_seq_pkg
//   Shared definitions for the instruction-execute stack sequencer:
//     - stack operation codes (push / pull)
//     - FSM state encodings and the state enum built on them
//     - stack_addr(): forms the 16-bit bus address of a stack slot
//   No ports (package).
// ---------------------------------------------------------------------------
package ie_stack_seq_pkg;

  // Stack operation selected by the 'op' input.
  localparam logic STACK_PUSH = 1'b0;
  localparam logic STACK_PULL = 1'b1;

  // Sequencer state encodings.
  localparam logic [1:0] ST_IDLE_ENC    = 2'd0;
  localparam logic [1:0] ST_PUSH_ENC    = 2'd1;
  localparam logic [1:0] ST_PULL_RD_ENC = 2'd2;
  localparam logic [1:0] ST_DONE_ENC    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = ST_IDLE_ENC,
    ST_PUSH    = ST_PUSH_ENC,
    ST_PULL_RD = ST_PULL_RD_ENC,
    ST_DONE    = ST_DONE_ENC
  } stack_state_t;

  // The stack lives in a single 256-byte page; the pointer is the low byte.
  function automatic logic [15:0] stack_addr(input logic [7:0] page,
                                             input logic [7:0] ptr);
    return {page, ptr};
  endfunction

endpackage

// File: rtl/ie_wait_counter.sv
// ---------------------------------------------------------------------------
// ie_wait_counter
//   Loadable down-counter used to hold a bus address for a fixed number of
//   cycles. A load pulse starts a wait of LAT cycles; 'expired' is high in
//   the LAT-th cycle after the load edge (and stays high while idle).
//   Ports:
//     clk     in  system clock
//     rst     in  synchronous active-high reset
//     load    in  start a new LAT-cycle wait on this edge
//     expired out high in the final cycle of the wait
// ---------------------------------------------------------------------------
module ie_wait_counter #(
  parameter  int LAT = 2,
  localparam int CW  = $clog2(LAT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expired
);

  logic [CW-1:0] count_reg;

  // Loading LAT-1 makes the count reach zero in the LAT-th cycle, so a
  // single-cycle wait (LAT=1) expires in the very first cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= CW'(LAT - 1);
    end else if (count_reg != '0) begin
      count_reg <= count_reg - CW'(1);
    end
  end

  assign expired = (count_reg == '0);

endmodule

// File: rtl/ie_stack_seq.sv
// ---------------------------------------------------------------------------
// ie_stack_seq
//   Stack sequencer for the 6502 instruction-execute path. Runs multi-byte
//   push and pull bursts on the byte-wide memory bus (JSR/RTS/RTI and
//   interrupt entry), owns the stack pointer and reports page wrap.
//
//   Optional feature: define IE_STACK_GUARD_EN to abort any burst that would
//   wrap around the stack page (err=1, wrap=1, no bus activity, sp kept).
//   Without it the burst wraps modulo 256 and only wrap is flagged.
//
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     start, op         burst request (IDLE only), 0=push 1=pull
//     nbytes            burst length, clamped to MAX_BYTES
//     push_data         byte k at [8k+7:8k], byte 0 pushed first
//     sp_load,
//     sp_load_val       load the stack pointer (IDLE only)
//     busy, done        activity flag, one-cycle completion pulse
//     wrap, err         burst status, valid from done until next start
//     pull_data         byte k = k-th byte pulled
//     sp_out            current stack pointer
//     mem_addr,
//     mem_data_out,
//     mem_data_in,
//     mem_write_en,
//     mem_read_en       CPU memory bus
// ---------------------------------------------------------------------------
module ie_stack_seq
  import ie_stack_seq_pkg::*;
#(
  parameter  int         MAX_BYTES  = 3,
  parameter  int         READ_LAT   = 2,
  parameter  logic [7:0] STACK_PAGE = 8'h01,
  parameter  logic [7:0] SP_RESET   = 8'hFF,
  localparam int         NB_W       = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   op,
  input  logic [NB_W-1:0]        nbytes,
  input  logic [8*MAX_BYTES-1:0] push_data,
  input  logic                   sp_load,
  input  logic [7:0]             sp_load_val,
  output logic                   busy,
  output logic                   done,
  output logic                   wrap,
  output logic                   err,
  output logic [8*MAX_BYTES-1:0] pull_data,
  output logic [7:0]             sp_out,
  output logic [15:0]            mem_addr,
  output logic [7:0]             mem_data_out,
  input  logic [7:0]             mem_data_in,
  output logic                   mem_write_en,
  output logic                   mem_read_en
);

`ifdef IE_STACK_GUARD_EN
  localparam bit GUARD_EN = 1'b1;
`else
  localparam bit GUARD_EN = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  stack_state_t           state_reg;
  logic [NB_W-1:0]        nb_reg;
  logic [NB_W-1:0]        idx_reg;
  logic [8*MAX_BYTES-1:0] push_buf_reg;
  logic [7:0]             pull_bytes_reg [MAX_BYTES];
  logic [7:0]             sp_reg;
  logic [15:0]            mem_addr_reg;
  logic [7:0]             mem_data_out_reg;
  logic                   mem_write_en_reg;
  logic                   mem_read_en_reg;
  logic                   busy_reg;
  logic                   done_reg;
  logic                   wrap_reg;
  logic                   err_reg;

  // -------------------------------------------------------------------------
  // Byte lane views of the captured push data and the pull result
  // -------------------------------------------------------------------------
  logic [7:0] push_bytes [MAX_BYTES];

  genvar gi;
  generate
    for (gi = 0; gi < MAX_BYTES; gi++) begin : g_lanes
      assign push_bytes[gi]           = push_buf_reg[8*gi +: 8];
      assign pull_data[8*gi +: 8]     = pull_bytes_reg[gi];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Start-of-burst decode
  // -------------------------------------------------------------------------
  logic [NB_W-1:0] nb_clamped;
  logic [7:0]      sp_start;
  logic            wrap_calc;
  logic            guard_hit;
  logic            idle_go;

  assign nb_clamped = (nbytes > NB_W'(MAX_BYTES)) ? NB_W'(MAX_BYTES) : nbytes;

  // A simultaneous sp_load feeds the burst directly.
  assign sp_start = sp_load ? sp_load_val : sp_reg;

  // Push walks down from sp; pull walks up from sp+1.
  assign wrap_calc = (op == STACK_PUSH)
                   ? (sp_start < 8'(nb_clamped))
                   : (({1'b0, sp_start} + 9'(nb_clamped)) > 9'd255);

  assign guard_hit = GUARD_EN && wrap_calc;
  assign idle_go   = (state_reg == ST_IDLE) && start;

  // -------------------------------------------------------------------------
  // In-burst decode
  // -------------------------------------------------------------------------
  logic [NB_W-1:0] idx_next;
  logic            last_byte;
  logic [7:0]      sp_pull_next;
  logic            cnt_load;
  logic            cnt_expired;

  assign idx_next  = idx_reg + NB_W'(1);
  assign last_byte = (idx_reg == (nb_reg - NB_W'(1)));

  // The pull pointer steps in the first cycle of each byte, which is exactly
  // the cycle carrying the read strobe.
  assign sp_pull_next = mem_read_en_reg ? (sp_reg + 8'd1) : sp_reg;

  // Restart the wait on entry to a pull and between pull bytes.
  assign cnt_load = (idle_go && (op == STACK_PULL) && (nb_clamped != '0) && !guard_hit)
                  || ((state_reg == ST_PULL_RD) && cnt_expired && !last_byte);

  ie_wait_counter #(
    .LAT (READ_LAT)
  ) u_wait (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .expired (cnt_expired)
  );

  // -------------------------------------------------------------------------
  // Sequencer FSM with registered bus and status outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      nb_reg           <= '0;
      idx_reg          <= '0;
      push_buf_reg     <= '0;
      for (int i = 0; i < MAX_BYTES; i++) pull_bytes_reg[i] <= '0;
      sp_reg           <= SP_RESET;
      mem_addr_reg     <= '0;
      mem_data_out_reg <= '0;
      mem_write_en_reg <= 1'b0;
      mem_read_en_reg  <= 1'b0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      wrap_reg         <= 1'b0;
      err_reg          <= 1'b0;
    end else begin
      // Strobes and the done pulse last a single cycle unless re-armed.
      mem_write_en_reg <= 1'b0;
      mem_read_en_reg  <= 1'b0;
      done_reg         <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (sp_load) begin
            sp_reg <= sp_load_val;
          end
          if (start) begin
            nb_reg       <= nb_clamped;
            idx_reg      <= '0;
            push_buf_reg <= push_data;
            wrap_reg     <= wrap_calc;
            err_reg      <= guard_hit;
            busy_reg     <= 1'b1;
            if (op == STACK_PULL) begin
              for (int i = 0; i < MAX_BYTES; i++) pull_bytes_reg[i] <= '0;
            end
            if ((nb_clamped == '0) || guard_hit) begin
              // Nothing to move: report completion without touching the bus.
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
            end else if (op == STACK_PUSH) begin
              state_reg        <= ST_PUSH;
              mem_addr_reg     <= stack_addr(STACK_PAGE, sp_start);
              mem_data_out_reg <= push_data[7:0];
              mem_write_en_reg <= 1'b1;
            end else begin
              state_reg       <= ST_PULL_RD;
              mem_addr_reg    <= stack_addr(STACK_PAGE, sp_start + 8'd1);
              mem_read_en_reg <= 1'b1;
            end
          end
        end

        ST_PUSH: begin
          // The write for byte idx is on the bus this cycle.
          sp_reg  <= sp_reg - 8'd1;
          idx_reg <= idx_next;
          if (last_byte) begin
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
          end else begin
            mem_addr_reg     <= stack_addr(STACK_PAGE, sp_reg - 8'd1);
            mem_data_out_reg <= push_bytes[idx_next];
            mem_write_en_reg <= 1'b1;
          end
        end

        ST_PULL_RD: begin
          sp_reg <= sp_pull_next;
          if (cnt_expired) begin
            pull_bytes_reg[idx_reg] <= mem_data_in;
            idx_reg                 <= idx_next;
            if (last_byte) begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
            end else begin
              mem_addr_reg    <= stack_addr(STACK_PAGE, sp_pull_next + 8'd1);
              mem_read_en_reg <= 1'b1;
            end
          end
        end

        ST_DONE: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end

        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = busy_reg;
  assign done         = done_reg;
  assign wrap         = wrap_reg;
  assign err          = err_reg;
  assign sp_out       = sp_reg;
  assign mem_addr     = mem_addr_reg;
  assign mem_data_out = mem_data_out_reg;
  assign mem_write_en = mem_write_en_reg;
  assign mem_read_en  = mem_read_en_reg;

endmodule

// File: tb/tb_ie_stack_seq.sv
// ---------------------------------------------------------------------------
// tb_ie_stack_seq
//   Directed bench for ie_stack_seq with a scoreboard of expected bus
//   strobes and completion records. Honours IE_STACK_GUARD_EN.
// ---------------------------------------------------------------------------
module tb_ie_stack_seq;
  import ie_stack_seq_pkg::*;

  localparam int MAX_BYTES = 3;
  localparam int READ_LAT  = 2;
  localparam int NB_W      = $clog2(MAX_BYTES + 1);

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic                   op;
  logic [NB_W-1:0]        nbytes;
  logic [8*MAX_BYTES-1:0] push_data;
  logic                   sp_load;
  logic [7:0]             sp_load_val;
  logic                   busy;
  logic                   done;
  logic                   wrap;
  logic                   err;
  logic [8*MAX_BYTES-1:0] pull_data;
  logic [7:0]             sp_out;
  logic [15:0]            mem_addr;
  logic [7:0]             mem_data_out;
  logic [7:0]             mem_data_in;
  logic                   mem_write_en;
  logic                   mem_read_en;

  always #5 clk = ~clk;

  // Read-side memory image owned by the bench.
  logic [7:0] rd_mem [0:65535];
  assign mem_data_in = rd_mem[mem_addr];

  ie_stack_seq #(
    .MAX_BYTES  (MAX_BYTES),
    .READ_LAT   (READ_LAT),
    .STACK_PAGE (8'h01),
    .SP_RESET   (8'hFF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .op           (op),
    .nbytes       (nbytes),
    .push_data    (push_data),
    .sp_load      (sp_load),
    .sp_load_val  (sp_load_val),
    .busy         (busy),
    .done         (done),
    .wrap         (wrap),
    .err          (err),
    .pull_data    (pull_data),
    .sp_out       (sp_out),
    .mem_addr     (mem_addr),
    .mem_data_out (mem_data_out),
    .mem_data_in  (mem_data_in),
    .mem_write_en (mem_write_en),
    .mem_read_en  (mem_read_en)
  );

  typedef struct {
    int          cyc;
    logic [15:0] addr;
    logic [7:0]  data;
  } bus_t;

  typedef struct {
    int          cyc;
    logic [7:0]  sp;
    logic        wrap;
    logic        err;
    logic [23:0] pdata;
  } done_t;

  bus_t  exp_wr[$];
  bus_t  exp_rd[$];
  done_t exp_done[$];

  int total = 0;
  int bad   = 0;

  logic [7:0]  model_sp   = 8'hFF;
  logic [23:0] model_pull = 24'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Queue expectations for one burst, start it, then watch the bus until
  // done. With poke set, a second start/sp_load is fired while busy.
  task automatic go(input logic opv, input int nb, input logic [23:0] pd,
                    input bit ld, input logic [7:0] lv, input bit poke);
    logic [7:0] sp0;
    int         nbc;
    bit         wr;
    bit         gd;
    bus_t       b;
    done_t      d;
    done_t      got_d;
    int         n;
    bit         got;

    sp0 = ld ? lv : model_sp;
    nbc = (nb > MAX_BYTES) ? MAX_BYTES : nb;
    wr  = opv ? ((int'(sp0) + nbc) > 255) : (int'(sp0) < nbc);
`ifdef IE_STACK_GUARD_EN
    gd = wr;
`else
    gd = 1'b0;
`endif
    if (opv) model_pull = 24'h0;
    if (!gd) begin
      for (int k = 0; k < nbc; k++) begin
        if (!opv) begin
          b.cyc  = k + 1;
          b.addr = {8'h01, sp0 - 8'(k)};
          b.data = pd[8*k +: 8];
          exp_wr.push_back(b);
        end else begin
          b.cyc  = k * READ_LAT + 1;
          b.addr = {8'h01, sp0 + 8'(k + 1)};
          b.data = 8'h00;
          exp_rd.push_back(b);
          model_pull[8*k +: 8] = rd_mem[b.addr];
        end
      end
    end
    model_sp = gd ? sp0 : (opv ? sp0 + 8'(nbc) : sp0 - 8'(nbc));
    d.cyc   = ((nbc == 0) || gd) ? 1 : (opv ? nbc * READ_LAT + 1 : nbc + 1);
    d.sp    = model_sp;
    d.wrap  = wr;
    d.err   = gd;
    d.pdata = model_pull;
    exp_done.push_back(d);

    // Drive the request; inputs are scrambled after the start edge.
    op          = opv;
    nbytes      = NB_W'(nb);
    push_data   = pd;
    sp_load     = ld;
    sp_load_val = lv;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start       = 1'b0;
    sp_load     = 1'b0;
    op          = ~opv;
    push_data   = ~pd;

    n   = 0;
    got = 1'b0;
    while (!got && n < 50) begin
      @(negedge clk);
      n++;
      chk("busy", busy, 1);
      if (mem_write_en) begin
        if (exp_wr.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          b = exp_wr.pop_front();
          chk("wr_cyc", n, b.cyc);
          chk("wr_addr", mem_addr, b.addr);
          chk("wr_data", mem_data_out, b.data);
        end
      end
      if (mem_read_en) begin
        if (exp_rd.size() == 0) chk("unexpected_read", 1, 0);
        else begin
          b = exp_rd.pop_front();
          chk("rd_cyc", n, b.cyc);
          chk("rd_addr", mem_addr, b.addr);
        end
      end
      if (done) begin
        got   = 1'b1;
        got_d = exp_done.pop_front();
        chk("done_cyc", n, got_d.cyc);
        chk("done_sp", sp_out, got_d.sp);
        chk("done_wrap", wrap, got_d.wrap);
        chk("done_err", err, got_d.err);
        chk("done_pull", pull_data, got_d.pdata);
        $display("burst op=%0d nb=%0d sp0=%02h: cyc=%0d sp=%02h wrap=%b err=%b pull=%06h",
                 opv, nb, sp0, n, sp_out, wrap, err, pull_data);
      end
      if (poke && n == 1) begin
        start       = 1'b1;
        sp_load     = 1'b1;
        sp_load_val = 8'h10;
        op          = 1'b0;
        nbytes      = NB_W'(2);
        @(posedge clk);
        #1;
        start   = 1'b0;
        sp_load = 1'b0;
      end
    end
    if (!got) chk("done_timeout", 0, 1);
    chk("wr_left", exp_wr.size(), 0);
    chk("rd_left", exp_rd.size(), 0);
    exp_wr.delete();
    exp_rd.delete();
    exp_done.delete();

    // Back in IDLE with no stray second completion.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_sp", sp_out, model_sp);
    end
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    op          = 1'b0;
    nbytes      = '0;
    push_data   = '0;
    sp_load     = 1'b0;
    sp_load_val = 8'h00;
    rd_mem[16'h01FD] = 8'hAA;
    rd_mem[16'h01FE] = 8'hBB;
    rd_mem[16'h01FF] = 8'hCC;
    rd_mem[16'h0181] = 8'h5A;
    rd_mem[16'h0100] = 8'h11;
    rd_mem[16'h0101] = 8'h22;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_err", err, 0);
    chk("rst_we", mem_write_en, 0);
    chk("rst_re", mem_read_en, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_dout", mem_data_out, 0);
    chk("rst_pull", pull_data, 0);
    chk("rst_sp", sp_out, 8'hFF);
    rst = 1'b0;
    @(negedge clk);

    // Two-byte push from FF.
    go(STACK_PUSH, 2, 24'h003412, 1'b0, 8'h00, 1'b0);

    // Plain sp_load in IDLE.
    sp_load     = 1'b1;
    sp_load_val = 8'hFC;
    @(posedge clk);
    #1;
    sp_load = 1'b0;
    chk("sp_load", sp_out, 8'hFC);
    model_sp = 8'hFC;
    @(negedge clk);

    // Three-byte pull from FC.
    go(STACK_PULL, 3, 24'h0, 1'b0, 8'h00, 1'b0);

    // Push that wraps below the page (guard-dependent).
    go(STACK_PUSH, 3, 24'h564443, 1'b1, 8'h01, 1'b0);

    // sp_load together with a one-byte pull.
    go(STACK_PULL, 1, 24'h0, 1'b1, 8'h80, 1'b0);

    // Pull that wraps over the top of the page (guard-dependent).
    go(STACK_PULL, 3, 24'h0, 1'b1, 8'hFE, 1'b0);

    // Zero-length burst, with a start fired while busy.
    go(STACK_PUSH, 0, 24'h0, 1'b1, 8'h40, 1'b1);

    // Start fired during a longer push is also ignored.
    go(STACK_PUSH, 2, 24'h00BEEF, 1'b0, 8'h00, 1'b1);

    // Reset during the second byte of a three-byte push.
    op          = STACK_PUSH;
    nbytes      = NB_W'(3);
    push_data   = 24'h030201;
    sp_load     = 1'b1;
    sp_load_val = 8'hFF;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    sp_load = 1'b0;
    @(negedge clk);
    chk("mid_b0_we", mem_write_en, 1);
    chk("mid_b0_addr", mem_addr, 16'h01FF);
    @(negedge clk);
    chk("mid_b1_we", mem_write_en, 1);
    chk("mid_b1_addr", mem_addr, 16'h01FE);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_we", mem_write_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sp", sp_out, 8'hFF);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_addr", mem_addr, 0);
    $display("reset mid-burst: we=%b busy=%b sp=%02h", mem_write_en, busy, sp_out);
    rst        = 1'b0;
    model_sp   = 8'hFF;
    model_pull = 24'h0;
    @(negedge clk);

    // A fresh burst after reset.
    go(STACK_PUSH, 1, 24'h0000EE, 1'b0, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
